// File: rtl/s_axis_rq_arbiter.sv
// s_axis_rq_arbiter: two-requester AXI-Stream packet arbiter that feeds a single RQ adapter.
// Ownership is granted per packet with round-robin on ties. It is released only after the
// owner's tlast beat is accepted. Each packet costs one idle arbitration cycle.
// Optional stall watchdog: define RQ_ARB_WDOG_EN to build it. Without it, wdog_err reads 0.
module s_axis_rq_arbiter #(
    parameter int DATA_WIDTH  = 256,
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int WDOG_CYCLES = 1024
) (
    input  logic                  user_clk,
    input  logic                  user_reset_n,

    input  logic [DATA_WIDTH-1:0] s0_axis_rq_tdata,
    input  logic [KEEP_WIDTH-1:0] s0_axis_rq_tkeep,
    input  logic                  s0_axis_rq_tlast,
    input  logic [3:0]            s0_axis_rq_tuser,
    input  logic                  s0_axis_rq_tvalid,
    output logic                  s0_axis_rq_tready,

    input  logic [DATA_WIDTH-1:0] s1_axis_rq_tdata,
    input  logic [KEEP_WIDTH-1:0] s1_axis_rq_tkeep,
    input  logic                  s1_axis_rq_tlast,
    input  logic [3:0]            s1_axis_rq_tuser,
    input  logic                  s1_axis_rq_tvalid,
    output logic                  s1_axis_rq_tready,

    output logic [DATA_WIDTH-1:0] m_axis_rq_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_rq_tkeep,
    output logic                  m_axis_rq_tlast,
    output logic [3:0]            m_axis_rq_tuser,
    output logic                  m_axis_rq_tvalid,
    input  logic                  m_axis_rq_tready,

    output logic [1:0]            grant,
    output logic                  wdog_err,
    input  logic                  wdog_clr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [15:0] WDOG_LIMIT = 16'(WDOG_CYCLES - 1);

    state_t state_q, state_d;
    logic   last_owner_q, last_owner_d;
    logic   beat_accept;

    // State and last-owner registers; last_owner resets to 1 so s0 wins the first tie
    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
        end
    end

    // Next-state selection and the combinational output mux toward the adapter
    always_comb begin
        state_d           = state_q;
        last_owner_d      = last_owner_q;
        m_axis_rq_tdata   = '0;
        m_axis_rq_tkeep   = '0;
        m_axis_rq_tlast   = 1'b0;
        m_axis_rq_tuser   = 4'd0;
        m_axis_rq_tvalid  = 1'b0;
        s0_axis_rq_tready = 1'b0;
        s1_axis_rq_tready = 1'b0;
        grant             = 2'b00;
        beat_accept       = 1'b0;

        case (state_q)
            IDLE: begin
                if (s0_axis_rq_tvalid && s1_axis_rq_tvalid) begin
                    state_d = last_owner_q ? GNT0 : GNT1;
                end else if (s0_axis_rq_tvalid) begin
                    state_d = GNT0;
                end else if (s1_axis_rq_tvalid) begin
                    state_d = GNT1;
                end
            end

            GNT0: begin
                m_axis_rq_tdata   = s0_axis_rq_tdata;
                m_axis_rq_tkeep   = s0_axis_rq_tkeep;
                m_axis_rq_tlast   = s0_axis_rq_tlast;
                m_axis_rq_tuser   = s0_axis_rq_tuser;
                m_axis_rq_tvalid  = s0_axis_rq_tvalid;
                s0_axis_rq_tready = m_axis_rq_tready;
                grant             = 2'b01;
                beat_accept       = s0_axis_rq_tvalid && m_axis_rq_tready;
                if (beat_accept && s0_axis_rq_tlast) begin
                    state_d      = IDLE;
                    last_owner_d = 1'b0;
                end
            end

            GNT1: begin
                m_axis_rq_tdata   = s1_axis_rq_tdata;
                m_axis_rq_tkeep   = s1_axis_rq_tkeep;
                m_axis_rq_tlast   = s1_axis_rq_tlast;
                m_axis_rq_tuser   = s1_axis_rq_tuser;
                m_axis_rq_tvalid  = s1_axis_rq_tvalid;
                s1_axis_rq_tready = m_axis_rq_tready;
                grant             = 2'b10;
                beat_accept       = s1_axis_rq_tvalid && m_axis_rq_tready;
                if (beat_accept && s1_axis_rq_tlast) begin
                    state_d      = IDLE;
                    last_owner_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef RQ_ARB_WDOG_EN
    logic [15:0] wdog_cnt_q, wdog_cnt_d;
    logic        wdog_err_q, wdog_err_d;

    // Watchdog register bank, cleared with the rest of the arbiter
    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            wdog_cnt_q <= 16'd0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    // Count owner stall cycles mid-packet. The sticky error sets at the limit, and set beats clear.
    always_comb begin
        wdog_cnt_d = wdog_cnt_q;
        if (state_q == IDLE || state_d == IDLE || beat_accept) begin
            wdog_cnt_d = 16'd0;
        end else if (!m_axis_rq_tvalid && wdog_cnt_q != 16'hFFFF) begin
            wdog_cnt_d = wdog_cnt_q + 16'd1;
        end

        wdog_err_d = wdog_err_q && !wdog_clr;
        if (state_q != IDLE && wdog_cnt_q == WDOG_LIMIT) begin
            wdog_err_d = 1'b1;
        end
    end

    assign wdog_err = wdog_err_q;
`else
    logic [16:0] unused_wdog;

    assign unused_wdog = {wdog_clr, WDOG_LIMIT};
    assign wdog_err    = 1'b0;
`endif

endmodule

// File: doc/s_axis_rq_arbiter.md
S_AXIS_RQ_ARBITER -- requirements
Module: s_axis_rq_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256, the AXI-S data width.
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, the byte-keep width.
REQ-003 SHALL have parameter WDOG_CYCLES, default 1024, the mid-packet stall limit (macro build only).
REQ-004 SHALL have one clock and an asynchronous, active-low reset: user_clk  in  1  clock; user_reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have, per requester k in {0,1}: sk_axis_rq_tdata in DATA_WIDTH; sk_axis_rq_tkeep in KEEP_WIDTH; sk_axis_rq_tlast in 1; sk_axis_rq_tuser in 4; sk_axis_rq_tvalid in 1; sk_axis_rq_tready out 1.
REQ-006 SHALL have m_axis_rq_tdata out DATA_WIDTH; m_axis_rq_tkeep out KEEP_WIDTH; m_axis_rq_tlast out 1; m_axis_rq_tuser out 4; m_axis_rq_tvalid out 1; m_axis_rq_tready in 1. These feed the RQ adapter.
REQ-007 SHALL have grant out 2 (one-hot current owner, 00 when idle), wdog_err out 1 (sticky stall flag) and wdog_clr in 1 (clears wdog_err).

Function
REQ-008 SHALL use three states: IDLE, GNT0 and GNT1.
REQ-009 In IDLE: m_axis_rq_tvalid=0, both sk_tready=0, grant=00.
REQ-010 In IDLE with only sk_tvalid=1, SHALL enter GNTk on the next edge.
REQ-011 In IDLE with both tvalid=1, SHALL enter GNTk where k != last_owner (round-robin). last_owner resets to 1, so s0 wins the first tie.
REQ-012 In GNTk: m_axis_rq_{tdata,tkeep,tlast,tuser,tvalid} = sk equivalents (combinational mux); sk_tready = m_axis_rq_tready; other requester's tready=0; grant bit k=1.
REQ-013 Beat accepted when m_axis_rq_tvalid & m_axis_rq_tready.
REQ-014 On an accepted beat with tlast=1, SHALL go to IDLE and set last_owner<=k.
REQ-015 Non-last beats and stalls (tvalid=0 or tready=0) SHALL hold GNTk; no preemption mid-packet.
REQ-016 Arbitration costs exactly one IDLE bubble cycle per packet; max throughput for N-beat packets is N/(N+1).
REQ-017 A single-beat packet (tlast on first beat) SHALL be granted and released identically to multi-beat packets.
REQ-018 Input data SHALL pass unmodified; the adapter handles header translation and first/last BE.
REQ-019 Requester tvalid deasserting in IDLE before grant takes effect: SHALL still enter GNTk and wait (AXI-S forbids this; no recovery is required).

Reset
REQ-020 Asserting user_reset_n low SHALL immediately force state=IDLE, last_owner=1, wdog counter=0 and wdog_err=0, so all outputs read as in REQ-009.
REQ-021 Reset mid-packet SHALL abandon the packet; no resume after release.
REQ-022 The first grant SHALL be evaluated on the first edge after user_reset_n deasserts.

Configuration
REQ-023 Macro RQ_ARB_WDOG_EN SHALL select the stall watchdog.
REQ-024 With RQ_ARB_WDOG_EN defined: a 16-bit counter SHALL clear on every accepted beat and on IDLE entry.
REQ-025 With RQ_ARB_WDOG_EN defined: in GNTk with the owner's tvalid=0, the counter SHALL increment and saturate.
REQ-026 With RQ_ARB_WDOG_EN defined: when the counter reaches WDOG_CYCLES-1, wdog_err SHALL set on the next edge and stay set until wdog_clr=1; set wins over a simultaneous clr.
REQ-027 With RQ_ARB_WDOG_EN defined: the watchdog SHALL NOT alter the grant.
REQ-028 Without RQ_ARB_WDOG_EN: no counter is present, wdog_err=0 constant, wdog_clr is ignored, and the ports remain present.

Verification
REQ-029 s0 sends a 3-beat packet with m_tready=1 -> grant=01 one cycle after s0 tvalid; 3 beats out, unchanged; IDLE after beat 3.
REQ-030 s0 and s1 continuously valid with 2-beat packets -> grants alternate 01,10,01,...; s0 first; one idle cycle between packets.
REQ-031 s1 mid-packet with m_tready toggling 1,0,1 and s0 valid -> no switch until s1 tlast is accepted; s0 beats are never accepted.
REQ-032 Single-beat packets back-to-back on s0 only -> m_tvalid pattern 0,1,0,1 (50% throughput).
REQ-033 user_reset_n pulsed low during beat 2 of 4 on s1 -> outputs zero immediately; after release with both valid, s0 is granted first.
REQ-034 RQ_ARB_WDOG_EN, WDOG_CYCLES=8, s0 drops tvalid after beat 1 for 10 cycles -> wdog_err=1 on cycle 8, grant stays 01; wdog_clr pulse -> 0.
